length_prefixed_field_reader: RTL and testbench

- Downstream consumer of the variable-length argument decoder's bit window.
- Each field is a LOG2_WIDTH-bit length prefix L followed by an L-bit payload.
- Strips the prefix, extracts the payload zero-extended to WIDTH bits, and returns consumed bit counts on pop.
- Presents one field per valid/ready transfer to the argument-execution logic.

---
 rtl/length_prefixed_field_reader.sv | 90 +++++++++
 tb/tb_length_prefixed_field_reader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/length_prefixed_field_reader.sv
// Strips a LOG2_WIDTH-bit length prefix from the decoder window and presents the
// following zero-extended payload as one field per valid/ready transfer.
module length_prefixed_field_reader #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned LOG2_WIDTH  = 6,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       win,
    input  logic                   win_ready,
    output logic [LOG2_WIDTH-1:0]  pop,
    output logic [WIDTH-1:0]       field_q,
    output logic [LOG2_WIDTH-1:0]  field_len,
    output logic                   field_vld,
    input  logic                   field_rdy,
    output logic [COUNT_WIDTH-1:0] field_count
);

    typedef enum logic [0:0] {StHdr, StFld} state_e;

    state_e                state_q, state_d;
    logic [LOG2_WIDTH-1:0] len_q, len_d;
    logic                  load_ok;
    logic                  load;
    logic [WIDTH-1:0]      mask;

    assign load_ok = !field_vld || field_rdy;
    // A zero-length field needs no window bits, so it loads without win_ready.
    assign load    = (state_q == StFld) && load_ok && ((len_q == '0) || win_ready);
    assign mask    = ~({WIDTH{1'b1}} << len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHdr;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        unique case (state_q)
            StHdr: begin
                if (win_ready) begin
                    len_d   = win[LOG2_WIDTH-1:0];
                    state_d = StFld;
                end
            end
            StFld: begin
                if (load) begin
                    state_d = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    // pop is held at zero during reset even though state already reads StHdr.
    always_comb begin
        pop = '0;
        if (rst_n) begin
            unique case (state_q)
                StHdr:   if (win_ready) pop = LOG2_WIDTH'(LOG2_WIDTH);
                StFld:   if (load) pop = len_q;
                default: pop = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q     <= '0;
            field_len   <= '0;
            field_vld   <= 1'b0;
            field_count <= '0;
        end else if (load) begin
            field_q     <= win & mask;
            field_len   <= len_q;
            field_vld   <= 1'b1;
            field_count <= field_count + COUNT_WIDTH'(1);
        end else if (field_vld && field_rdy) begin
            field_vld   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_length_prefixed_field_reader.sv
// Bench: the bench acts as the upstream decoder over a bit queue and checks
// emitted fields against lengths/payloads parsed from the generated stream.
module tb_length_prefixed_field_reader;

    localparam int unsigned W  = 64;
    localparam int unsigned LW = 6;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  win;
    logic          win_ready;
    logic [LW-1:0] pop;
    logic [W-1:0]  field_q;
    logic [LW-1:0] field_len;
    logic          field_vld;
    logic          field_rdy;
    logic [CW-1:0] field_count;

    always #5 clk = ~clk;

    length_prefixed_field_reader #(.WIDTH(W), .LOG2_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .win         (win),
        .win_ready   (win_ready),
        .pop         (pop),
        .field_q     (field_q),
        .field_len   (field_len),
        .field_vld   (field_vld),
        .field_rdy   (field_rdy),
        .field_count (field_count)
    );

    bit            bitq[$];
    logic          starve;
    int            n_vec = 0;
    int            n_err = 0;

    logic [LW-1:0] s_pop;
    logic          s_vld;
    logic          s_wr;
    logic [W-1:0]  s_q;
    logic [LW-1:0] s_len;
    logic [CW-1:0] s_cnt;

    function automatic logic [W-1:0] lo_mask(int n);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic push_val(logic [W-1:0] v, int n);
        for (int i = 0; i < n; i++) bitq.push_back(v[i]);
    endtask

    task automatic push_field(int len, logic [W-1:0] v);
        push_val(W'(len), int'(LW));
        push_val(v, len);
    endtask

    task automatic drive_win();
        logic [W-1:0] w;
        if (bitq.size() >= W && !starve) begin
            for (int i = 0; i < int'(W); i++) w[i] = bitq[i];
            win_ready = 1'b1;
        end else begin
            w = {$urandom, $urandom};
            win_ready = 1'b0;
        end
        win = w;
    endtask

    task automatic sample();
        s_pop = pop;
        s_vld = field_vld;
        s_wr  = win_ready;
        s_q   = field_q;
        s_len = field_len;
        s_cnt = field_count;
    endtask

    // One cycle: drive at the falling edge, sample, then consume popped bits.
    task automatic step();
        drive_win();
        #1;
        sample();
        @(posedge clk);
        for (int i = 0; i < int'(s_pop); i++) if (bitq.size() > 0) void'(bitq.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bitq.delete();
        starve = 1'b0;
        field_rdy = 1'b0;
        drive_win();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bitq.delete();
        starve = 1'b0;
        push_val({$urandom, $urandom}, 64);
        push_val({$urandom, $urandom}, 64);
        field_rdy = 1'($urandom);
        @(negedge clk);
        drive_win();
        #1;
        sample();
        n_vec += 4;
        if (s_pop !== '0) begin n_err++; $display("FAIL reset_pop got %0d want 0", s_pop); end
        if (s_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %0b want 0", s_vld); end
        if (s_q !== '0) begin n_err++; $display("FAIL reset_q got %h want 0", s_q); end
        if (s_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", s_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if (s_pop !== LW'(6)) begin n_err++; $display("FAIL reset_first_pop got %0d want 6", s_pop); end
    endtask

    task automatic test_basic();
        do_reset();
        field_rdy = 1'b1;
        push_field(5, W'(5'b10101));
        push_val('1, 64);
        step();
        n_vec++;
        if (s_pop !== LW'(6)) begin n_err++; $display("FAIL basic_pop_hdr got %0d want 6", s_pop); end
        step();
        n_vec++;
        if (s_pop !== LW'(5)) begin n_err++; $display("FAIL basic_pop_fld got %0d want 5", s_pop); end
        step();
        n_vec += 4;
        if (s_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld got %0b want 1", s_vld); end
        if (s_q !== W'(64'h15)) begin n_err++; $display("FAIL basic_q got %h want 15", s_q); end
        if (s_len !== LW'(5)) begin n_err++; $display("FAIL basic_len got %0d want 5", s_len); end
        if (s_cnt !== CW'(1)) begin n_err++; $display("FAIL basic_cnt got %0d want 1", s_cnt); end
    endtask

    task automatic test_zero_and_max();
        do_reset();
        field_rdy = 1'b1;
        push_field(0, '0);
        push_field(63, '1);
        push_val('1, 64);
        step();
        n_vec++;
        if (s_pop !== LW'(6)) begin n_err++; $display("FAIL zero_pop_hdr got %0d want 6", s_pop); end
        starve = 1'b1;
        step();
        n_vec++;
        if (s_pop !== '0) begin n_err++; $display("FAIL zero_pop_fld got %0d want 0", s_pop); end
        starve = 1'b0;
        step();
        n_vec += 4;
        if (s_vld !== 1'b1 || s_q !== '0 || s_len !== '0) begin
            n_err++;
            $display("FAIL zero_field got vld=%0b q=%h len=%0d want 1/0/0", s_vld, s_q, s_len);
        end
        if (s_cnt !== CW'(1)) begin n_err++; $display("FAIL zero_cnt got %0d want 1", s_cnt); end
        if (s_pop !== LW'(6)) begin n_err++; $display("FAIL max_pop_hdr got %0d want 6", s_pop); end
        step();
        if (s_pop !== LW'(63)) begin n_err++; $display("FAIL max_pop_fld got %0d want 63", s_pop); end
        step();
        n_vec += 2;
        if (s_q !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            n_err++; $display("FAIL max_q got %h want 7fffffffffffffff", s_q);
        end
        if (s_len !== LW'(63)) begin n_err++; $display("FAIL max_len got %0d want 63", s_len); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_field(8, W'(8'hA5));
        push_field(4, W'(4'h9));
        push_val('1, 64);
        step();
        step();
        step();
        n_vec += 2;
        if (s_pop !== LW'(6)) begin n_err++; $display("FAIL bp_hdr_pop got %0d want 6", s_pop); end
        if (s_q !== W'(64'hA5)) begin n_err++; $display("FAIL bp_first_q got %h want a5", s_q); end
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec += 2;
            if (s_pop !== '0) begin n_err++; $display("FAIL bp_stall_pop got %0d want 0", s_pop); end
            if (s_q !== W'(64'hA5) || s_vld !== 1'b1) begin
                n_err++; $display("FAIL bp_hold got q=%h vld=%0b want a5/1", s_q, s_vld);
            end
        end
        field_rdy = 1'b1;
        step();
        n_vec++;
        if (s_pop !== LW'(4)) begin n_err++; $display("FAIL bp_release_pop got %0d want 4", s_pop); end
        field_rdy = 1'b0;
        step();
        n_vec++;
        if (s_vld !== 1'b1 || s_q !== W'(64'h9) || s_len !== LW'(4) || s_cnt !== CW'(2)) begin
            n_err++;
            $display("FAIL bp_second got vld=%0b q=%h len=%0d cnt=%0d want 1/9/4/2",
                     s_vld, s_q, s_len, s_cnt);
        end
    endtask

    task automatic test_starvation();
        logic [W-1:0] v;
        v = {$urandom, $urandom} & lo_mask(10);
        do_reset();
        field_rdy = 1'b1;
        push_field(10, v);
        push_val({$urandom, $urandom}, 64);
        step();
        starve = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if (s_pop !== '0 || s_vld !== 1'b0) begin
                n_err++; $display("FAIL starve_hold got pop=%0d vld=%0b want 0/0", s_pop, s_vld);
            end
        end
        starve = 1'b0;
        step();
        n_vec++;
        if (s_pop !== LW'(10)) begin n_err++; $display("FAIL starve_pop got %0d want 10", s_pop); end
        step();
        n_vec++;
        if (s_q !== v || s_len !== LW'(10)) begin
            n_err++; $display("FAIL starve_field got q=%h len=%0d want %h/10", s_q, s_len, v);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_field(5, W'(5'h0B));
        push_field(12, {$urandom, $urandom} & lo_mask(12));
        push_val({$urandom, $urandom}, 64);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        n_vec++;
        if (s_pop !== '0 || s_vld !== 1'b0 || s_q !== '0 || s_len !== '0 || s_cnt !== '0) begin
            n_err++;
            $display("FAIL midreset got pop=%0d vld=%0b q=%h len=%0d cnt=%0d want all 0",
                     s_pop, s_vld, s_q, s_len, s_cnt);
        end
        @(negedge clk);
        bitq.delete();
        push_field(3, W'(3'b111));
        push_val({$urandom, $urandom}, 64);
        rst_n = 1'b1;
        field_rdy = 1'b1;
        step();
        step();
        n_vec++;
        if (s_pop !== LW'(3)) begin n_err++; $display("FAIL midreset_pop got %0d want 3", s_pop); end
        step();
        n_vec++;
        if (s_q !== W'(64'h7) || s_len !== LW'(3)) begin
            n_err++; $display("FAIL midreset_field got q=%h len=%0d want 7/3", s_q, s_len);
        end
    endtask

    task automatic test_random();
        int           exp_len[$];
        logic [W-1:0] exp_val[$];
        logic         hold;
        logic [W-1:0] hold_q;
        logic [LW-1:0] hold_len;
        int           len;
        logic [W-1:0] v;
        int           cyc;
        do_reset();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : 63;
            else len = $urandom_range(1, 62);
            v = {$urandom, $urandom} & lo_mask(len);
            push_field(len, v);
            exp_len.push_back(len);
            exp_val.push_back(v);
        end
        push_val({$urandom, $urandom}, 64);
        hold = 1'b0;
        hold_q = '0;
        hold_len = '0;
        cyc = 0;
        while (exp_len.size() > 0 && cyc < 4000) begin
            starve = ($urandom_range(0, 3) == 0);
            field_rdy = ($urandom_range(0, 2) != 0);
            step();
            cyc++;
            n_vec++;
            if (s_pop !== '0 && !s_wr) begin
                n_err++; $display("FAIL rnd_pop_unready got %0d want 0", s_pop);
            end
            if (hold) begin
                n_vec++;
                if (!s_vld || s_q !== hold_q || s_len !== hold_len) begin
                    n_err++;
                    $display("FAIL rnd_stable got q=%h len=%0d want %h/%0d",
                             s_q, s_len, hold_q, hold_len);
                end
            end
            if (s_vld && field_rdy) begin
                n_vec++;
                if (s_len !== LW'(exp_len[0]) || s_q !== exp_val[0]) begin
                    n_err++;
                    $display("FAIL rnd_field got q=%h len=%0d want %h/%0d",
                             s_q, s_len, exp_val[0], exp_len[0]);
                end
                void'(exp_len.pop_front());
                void'(exp_val.pop_front());
            end
            hold = s_vld && !field_rdy;
            hold_q = s_q;
            hold_len = s_len;
        end
        n_vec++;
        if (exp_len.size() != 0) begin
            n_err++; $display("FAIL rnd_timeout got %0d fields left want 0", exp_len.size());
        end
    endtask

    initial begin
        starve = 1'b0;
        field_rdy = 1'b0;
        win = '0;
        win_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_and_max();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
